cpu_step_ctrl: RTL

Run/step controller sitting directly downstream of the clock divider: consumes the divided slow clock as a data signal in the `clk` domain and turns its rising edges into single-cycle `cpu_en` pulses that advance the single-cycle processor. Supports free-run, debounced single-step and halt modes, so the whole core stays on one clock with an enable instead of a derived clock. Also counts executed instructions for the board display.

---
 rtl/cpu_step_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/cpu_step_ctrl.sv
// Run/step controller: turns divided-clock rising edges into one-cycle cpu_en pulses
// under free-run, debounced single-step or halt control, and counts issued pulses.
module cpu_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             slow_clk,
  input  logic             btn_step,
  input  logic             sw_run,
  input  logic             halt_in,
  output logic             cpu_en,
  output logic [1:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] step_count
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    STEP = 2'b10,
    HALT = 2'b11
  } state_t;

  // Counter value on the edge before acceptance, so btn_stable moves DEBOUNCE_CYCLES-1 edges after btn_s.
  localparam logic [19:0] DB_LAST = 20'(DEBOUNCE_CYCLES - 2);

  logic        slow_m, slow_s, slow_prev;
  logic        btn_m, btn_s;
  logic        run_m, sw_run_s;
  logic        btn_stable, btn_stable_prev;
  logic [19:0] db_cnt;
  logic        slow_rise, step_press;
  state_t      cur, nxt;
  logic        en_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      slow_m    <= 1'b0;
      slow_s    <= 1'b0;
      slow_prev <= 1'b0;
      btn_m     <= 1'b0;
      btn_s     <= 1'b0;
      run_m     <= 1'b0;
      sw_run_s  <= 1'b0;
    end else begin
      slow_m    <= slow_clk;
      slow_s    <= slow_m;
      slow_prev <= slow_s;
      btn_m     <= btn_step;
      btn_s     <= btn_m;
      run_m     <= sw_run;
      sw_run_s  <= run_m;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_stable      <= 1'b0;
      btn_stable_prev <= 1'b0;
      db_cnt          <= '0;
    end else begin
      btn_stable_prev <= btn_stable;
      if (btn_s == btn_stable) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        btn_stable <= btn_s;
        db_cnt     <= '0;
      end else begin
        db_cnt <= db_cnt + 20'd1;
      end
    end
  end

  assign slow_rise  = slow_s & ~slow_prev;
  assign step_press = btn_stable & ~btn_stable_prev;

  always_comb begin
    nxt    = cur;
    en_nxt = 1'b0;
    case (cur)
      IDLE: begin
        if (halt_in)         nxt = HALT;
        else if (sw_run_s)   nxt = RUN;
        else if (step_press) nxt = STEP;
      end
      RUN: begin
        if (halt_in)        nxt = HALT;
        else if (!sw_run_s) nxt = IDLE;
        else if (slow_rise) en_nxt = 1'b1;
      end
      STEP: begin
        if (halt_in) begin
          nxt = HALT;
        end else if (slow_rise) begin
          en_nxt = 1'b1;
          nxt    = IDLE;
        end
      end
      HALT: nxt = HALT;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur        <= IDLE;
      cpu_en     <= 1'b0;
      step_count <= '0;
    end else begin
      cur    <= nxt;
      cpu_en <= en_nxt;
      if (en_nxt && (step_count != '1))
        step_count <= step_count + CNT_W'(1);
    end
  end

  assign state  = cur;
  assign halted = (cur == HALT);

endmodule
